// File: rtl/path_replayer_pkg.sv
// Shared constants for the path replayer: move directions, FSM encoding and
// the counter width helper.
`ifndef PATH_REPLAYER_BITS_DEFINED
`define PATH_REPLAYER_BITS_DEFINED
`define BITS(n) ($clog2(n)+1)
`endif

package path_replayer_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Opposite direction is the bitwise complement of the code.
  function automatic logic [1:0] eff_code(input logic [1:0] code, input logic rev);
    return rev ? ~code : code;
  endfunction

endpackage

// File: rtl/path_replayer_move_step.sv
// Combinational cursor step: applies one move code to (x, y), modulo grid size,
// and flags any wrap off the grid edge.
module move_step
  import path_replayer_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int COORD_BITS = 4,
  parameter int REVERSE    = 1
) (
  input  logic [WIDTH-1:0]      code,
  input  logic [COORD_BITS-1:0] x,
  input  logic [COORD_BITS-1:0] y,
  output logic [COORD_BITS-1:0] nx,
  output logic [COORD_BITS-1:0] ny,
  output logic                  wrap
);

  localparam logic [COORD_BITS-1:0] ONE = COORD_BITS'(1);

  logic [1:0] c;

  always_comb begin
    c    = eff_code(code[1:0], REVERSE != 0);
    nx   = x;
    ny   = y;
    wrap = 1'b0;
    case (c)
      DIR_UP: begin
        ny   = y - ONE;
        wrap = (y == '0);
      end
      DIR_RIGHT: begin
        nx   = x + ONE;
        wrap = (x == '1);
      end
      DIR_LEFT: begin
        nx   = x - ONE;
        wrap = (x == '0);
      end
      default: begin
        ny   = y + ONE;
        wrap = (y == '1);
      end
    endcase
  end

endmodule

// File: rtl/path_replayer.sv
// Reads the move list back out on start, walks an (x, y) cursor one move per
// accepted code, and pulses done when the list reports end of stream.
module path_replayer
  import path_replayer_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int COORD_BITS = 4,
  parameter int MAX_LENGTH = 256,
  parameter int REVERSE    = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic [COORD_BITS-1:0]         start_x,
  input  logic [COORD_BITS-1:0]         start_y,
  output logic                          en_read,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          data_valid,
  input  logic                          read_done,
  output logic [COORD_BITS-1:0]         x_out,
  output logic [COORD_BITS-1:0]         y_out,
  output logic                          out_valid,
  output logic [`BITS(MAX_LENGTH)-1:0]  move_count,
  output logic                          busy,
  output logic                          done,
  output logic                          oob
);

  localparam int            CW      = `BITS(MAX_LENGTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LENGTH);

  logic [1:0]            state;
  logic [COORD_BITS-1:0] nx, ny;
  logic                  wrap;

  move_step #(
    .WIDTH     (WIDTH),
    .COORD_BITS(COORD_BITS),
    .REVERSE   (REVERSE)
  ) u_step (
    .code(data_in),
    .x   (x_out),
    .y   (y_out),
    .nx  (nx),
    .ny  (ny),
    .wrap(wrap)
  );

  // Decoded straight from state so an async reset clears them immediately.
  assign en_read = (state == S_REQ);
  assign busy    = (state == S_REQ) || (state == S_WAIT);
  assign done    = (state == S_FIN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      x_out      <= '0;
      y_out      <= '0;
      move_count <= '0;
      oob        <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_out      <= start_x;
            y_out      <= start_y;
            move_count <= '0;
            oob        <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          // A final move arriving with read_done is still applied.
          if (data_valid) begin
            x_out     <= nx;
            y_out     <= ny;
            out_valid <= 1'b1;
            if (wrap) oob <= 1'b1;
            if (move_count != CNT_MAX) move_count <= move_count + CW'(1);
          end
          if (read_done) state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_replayer.sv
// Directed bench: two replayers (REVERSE=1 and REVERSE=0) share one stimulus
// stream; expected cursors are hand-computed per direction.
module tb_path_replayer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [3:0] start_x = '0, start_y = '0;
  logic [1:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       read_done = 1'b0;

  logic       en_r, ov_r, busy_r, done_r, oob_r;
  logic [3:0] x_r, y_r;
  logic [8:0] mc_r;
  logic       en_f, ov_f, busy_f, done_f, oob_f;
  logic [3:0] x_f, y_f;
  logic [8:0] mc_f;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  path_replayer #(.WIDTH(2), .COORD_BITS(4), .MAX_LENGTH(256), .REVERSE(1)) dut_r (
    .CLK(CLK), .RST(RST), .start(start), .start_x(start_x), .start_y(start_y),
    .en_read(en_r), .data_in(data_in), .data_valid(data_valid), .read_done(read_done),
    .x_out(x_r), .y_out(y_r), .out_valid(ov_r), .move_count(mc_r),
    .busy(busy_r), .done(done_r), .oob(oob_r)
  );

  path_replayer #(.WIDTH(2), .COORD_BITS(4), .MAX_LENGTH(256), .REVERSE(0)) dut_f (
    .CLK(CLK), .RST(RST), .start(start), .start_x(start_x), .start_y(start_y),
    .en_read(en_f), .data_in(data_in), .data_valid(data_valid), .read_done(read_done),
    .x_out(x_f), .y_out(y_f), .out_valid(ov_f), .move_count(mc_f),
    .busy(busy_f), .done(done_f), .oob(oob_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Pulse start for one cycle; returns at the negedge where the FSM is in REQ.
  task automatic do_start(input logic [3:0] sx, input logic [3:0] sy);
    start = 1'b1; start_x = sx; start_y = sy;
    step();
    start = 1'b0;
  endtask

  task automatic move(input logic [1:0] code);
    data_valid = 1'b1; data_in = code;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    check("rst_x", x_r, 0);
    check("rst_mc", mc_r, 0);
    check("rst_en", en_r, 0);
    check("rst_busy", busy_r, 0);
    check("rst_oob", oob_r, 0);
    step();
    RST = 1'b0;
    step();

    // basic reversed replay from (5,5)
    do_start(4'd5, 4'd5);
    check("t1_en", en_r, 1);
    check("t1_busy", busy_r, 1);
    step();
    check("t1_en_once", en_r, 0);
    move(2'b01);
    check("t1_ov1", ov_r, 1);
    check("t1_xy1", {x_r, y_r}, {4'd4, 4'd5});
    move(2'b01);
    check("t1_xy2", {x_r, y_r}, {4'd3, 4'd5});
    move(2'b00);
    check("t1_xy3", {x_r, y_r}, {4'd3, 4'd6});
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("t1_done", done_r, 1);
    check("t1_busy_fin", busy_r, 0);
    check("t1_ov_fin", ov_r, 0);
    step();
    check("t1_done_pulse", done_r, 0);
    check("t1_mc", mc_r, 3);
    check("t1_oob", oob_r, 0);
    check("t1_hold", {x_r, y_r}, {4'd3, 4'd6});

    // forward wrap from (0,0)
    do_start(4'd0, 4'd0);
    step();
    move(2'b10);
    check("t2_f_xy", {x_f, y_f}, {4'd15, 4'd0});
    check("t2_f_oob", oob_f, 1);
    check("t2_r_xy", {x_r, y_r}, {4'd1, 4'd0});
    check("t2_r_oob", oob_r, 0);
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    step();
    check("t2_oob_sticky", oob_f, 1);

    // second start clears oob; empty list
    do_start(4'd7, 4'd9);
    check("t3_oob_clr", oob_f, 0);
    step();
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("t3_done", done_r, 1);
    check("t3_mc", mc_r, 0);
    check("t3_xy", {x_r, y_r}, {4'd7, 4'd9});
    step();

    // last move together with read_done
    do_start(4'd2, 4'd2);
    step();
    move(2'b11);
    check("t4_xy1", {x_r, y_r}, {4'd2, 4'd1});
    data_valid = 1'b1; data_in = 2'b10; read_done = 1'b1;
    step();
    data_valid = 1'b0; read_done = 1'b0;
    check("t4_done", done_r, 1);
    check("t4_xy2", {x_r, y_r}, {4'd3, 4'd1});
    check("t4_mc", mc_r, 2);
    check("t4_ov", ov_r, 1);
    step();

    // start while busy is ignored
    do_start(4'd1, 4'd1);
    step();
    start = 1'b1; start_x = 4'd9; start_y = 4'd9;
    step();
    start = 1'b0;
    check("t5_no_en", en_r, 0);
    check("t5_busy", busy_r, 1);
    check("t5_xy", {x_r, y_r}, {4'd1, 4'd1});
    move(2'b01);
    check("t5_xy_mv", {x_r, y_r}, {4'd0, 4'd1});
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("t5_done", done_r, 1);
    step();

    // reset mid-stream
    do_start(4'd5, 4'd5);
    step();
    move(2'b01);
    check("t6_pre_xy", {x_r, y_r}, {4'd4, 4'd5});
    #2 RST = 1'b1;
    #1;
    check("t6_async_x", x_r, 0);
    check("t6_async_y", y_r, 0);
    check("t6_async_ov", ov_r, 0);
    check("t6_async_busy", busy_r, 0);
    check("t6_async_mc", mc_r, 0);
    step();
    RST = 1'b0;
    move(2'b01);
    check("t6_idle_ov", ov_r, 0);
    check("t6_idle_x", x_r, 0);
    check("t6_idle_busy", busy_r, 0);
    do_start(4'd8, 4'd8);
    check("t6_en", en_r, 1);
    step();
    move(2'b11);
    check("t6_xy", {x_r, y_r}, {4'd8, 4'd7});
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("t6_done", done_r, 1);
    check("t6_mc", mc_r, 1);
    step();

    // counter saturation, cursor keeps moving
    do_start(4'd0, 4'd0);
    step();
    data_valid = 1'b1; data_in = 2'b01;
    repeat (258) step();
    data_valid = 1'b0;
    check("t7_mc_f", mc_f, 256);
    check("t7_x_f", x_f, 2);
    check("t7_oob_f", oob_f, 1);
    check("t7_mc_r", mc_r, 256);
    check("t7_x_r", x_r, 14);
    check("t7_oob_r", oob_r, 1);
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("t7_done", done_f, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
